// File: rtl/pack_seq.sv
// pack_seq: frame sequencer in front of the byte transmitter.
// Emits SYNC0 SYNC1 frame_cnt len_hi len_lo, fires the sample loader,
// forwards its byte stream and closes the frame with an 8-bit checksum.
// Optional CR/LF tail after the checksum: define PACK_SEQ_TAIL_EN.
module pack_seq #(
  parameter logic [7:0]  SYNC0   = 8'hEB,
  parameter logic [7:0]  SYNC1   = 8'h90,
  parameter logic [11:0] LEN_MAX = 12'd4000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        trig_pack,
  input  logic [11:0] len_cfg,
  output logic [11:0] len_load,
  output logic        fire_load,
  input  logic        done_load,
  input  logic [7:0]  load_data,
  input  logic        load_vld,
  output logic [7:0]  pk_data,
  output logic        pk_vld,
  output logic        pk_sop,
  output logic        pk_eop,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic        err_ovr,
  output logic        err_len,
  output logic        err_cnt
);

  typedef enum logic [3:0] {
    IDLE, H0, H1, H2, H3, H4, FIRE, LOAD, SUM,
`ifdef PACK_SEQ_TAIL_EN
    T0, T1,
`endif
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  csum_q;
  logic [15:0] pay_cnt_q;
  logic [15:0] pay_exp;

  logic        emit_vld, emit_sop, emit_eop;
  logic [7:0]  emit_data;
  logic        sum_en, pay_inc, accept, reject, overrun;

  assign pay_exp = {4'h0, len_load} * 16'd9;

  // State register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the byte each state produces
  always_comb begin
    state_d   = state_q;
    emit_vld  = 1'b0;
    emit_sop  = 1'b0;
    emit_eop  = 1'b0;
    emit_data = '0;
    sum_en    = 1'b0;
    pay_inc   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    fire_load = 1'b0;
    err_cnt   = 1'b0;
    busy      = (state_q != IDLE);
    overrun   = trig_pack && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (trig_pack) begin
          if ((len_cfg != '0) && (len_cfg <= LEN_MAX)) begin
            accept  = 1'b1;
            state_d = H0;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      H0: begin
        emit_vld  = 1'b1;
        emit_sop  = 1'b1;
        emit_data = SYNC0;
        state_d   = H1;
      end
      H1: begin
        emit_vld  = 1'b1;
        emit_data = SYNC1;
        state_d   = H2;
      end
      H2: begin
        emit_vld  = 1'b1;
        emit_data = frame_cnt;
        sum_en    = 1'b1;
        state_d   = H3;
      end
      H3: begin
        emit_vld  = 1'b1;
        emit_data = {4'h0, len_load[11:8]};
        sum_en    = 1'b1;
        state_d   = H4;
      end
      H4: begin
        emit_vld  = 1'b1;
        emit_data = len_load[7:0];
        sum_en    = 1'b1;
        state_d   = FIRE;
      end
      FIRE: begin
        fire_load = 1'b1;
        state_d   = LOAD;
      end
      LOAD: begin
        if (load_vld) begin
          emit_vld  = 1'b1;
          emit_data = load_data;
          sum_en    = 1'b1;
          pay_inc   = 1'b1;
        end
        if (done_load) state_d = SUM;
      end
      SUM: begin
        emit_vld  = 1'b1;
        emit_data = csum_q;
`ifdef PACK_SEQ_TAIL_EN
        state_d   = T0;
`else
        emit_eop  = 1'b1;
        state_d   = DONE;
`endif
      end
`ifdef PACK_SEQ_TAIL_EN
      T0: begin
        emit_vld  = 1'b1;
        emit_data = 8'h0D;
        state_d   = T1;
      end
      T1: begin
        emit_vld  = 1'b1;
        emit_eop  = 1'b1;
        emit_data = 8'h0A;
        state_d   = DONE;
      end
`endif
      DONE: begin
        err_cnt = (pay_cnt_q != pay_exp);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered byte stream, error pulses, length latch, checksum and counters
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pk_data   <= '0;
      pk_vld    <= 1'b0;
      pk_sop    <= 1'b0;
      pk_eop    <= 1'b0;
      err_ovr   <= 1'b0;
      err_len   <= 1'b0;
      len_load  <= '0;
      frame_cnt <= '0;
      csum_q    <= '0;
      pay_cnt_q <= '0;
    end else begin
      pk_data <= emit_data;
      pk_vld  <= emit_vld;
      pk_sop  <= emit_sop;
      pk_eop  <= emit_eop;
      err_ovr <= overrun;
      err_len <= reject;
      if (accept) begin
        len_load  <= len_cfg;
        csum_q    <= '0;
        pay_cnt_q <= '0;
      end else begin
        if (sum_en)  csum_q    <= csum_q + emit_data;
        if (pay_inc) pay_cnt_q <= pay_cnt_q + 16'd1;
      end
      if (state_q == DONE) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pack_seq.sv
// tb_pack_seq: table-driven frames with a byte scoreboard, plus hand-written
// timing, reject, overrun, wrap and mid-frame reset sequences.
module tb_pack_seq;

  localparam logic [7:0] SYNC0 = 8'hEB;
  localparam logic [7:0] SYNC1 = 8'h90;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig_pack = 1'b0;
  logic [11:0] len_cfg = '0;
  logic [11:0] len_load;
  logic        fire_load;
  logic        done_load = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_vld = 1'b0;
  logic [7:0]  pk_data;
  logic        pk_vld, pk_sop, pk_eop, busy;
  logic [7:0]  frame_cnt;
  logic        err_ovr, err_len, err_cnt;

  pack_seq dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .trig_pack(trig_pack), .len_cfg(len_cfg),
    .len_load(len_load), .fire_load(fire_load), .done_load(done_load),
    .load_data(load_data), .load_vld(load_vld), .pk_data(pk_data),
    .pk_vld(pk_vld), .pk_sop(pk_sop), .pk_eop(pk_eop), .busy(busy),
    .frame_cnt(frame_cnt), .err_ovr(err_ovr), .err_len(err_len), .err_cnt(err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_pass = 0;
  logic [9:0] exp_q[$];   // {sop, eop, data}
  bit mon_en = 1'b1;
  logic [7:0] m_fc = '0;

  typedef struct {
    logic [11:0] len;
    int          nbytes;
    int          ovr_at;
    bit          exp_cnt;
  } vec_t;
  vec_t vecs[6];

  function automatic void chk(string name, longint got, longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", name, got, want);
  endfunction

  // Scoreboard: every transmitted byte must match the head of the queue
  always @(negedge clk_sys) begin
    if (mon_en && pk_vld) begin
      if (exp_q.size() == 0) begin
        chk("pk_extra", longint'(pk_data), 256);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("pk_data", pk_data, e[7:0]);
        chk("pk_sop", pk_sop, e[9]);
        chk("pk_eop", pk_eop, e[8]);
      end
    end
  end

  task automatic run_frame(input logic [11:0] len, input int nbytes,
                           input int ovr_at, input bit exp_cnt, input bit chk_t);
    logic [7:0] cs, b;
    int fire_k, sop_k, ovr_seen, cnt_seen;
    logic busy1;
    cs = m_fc + {4'h0, len[11:8]} + len[7:0];
    exp_q.push_back({2'b10, SYNC0});
    exp_q.push_back({2'b00, SYNC1});
    exp_q.push_back({2'b00, m_fc});
    exp_q.push_back({2'b00, 4'h0, len[11:8]});
    exp_q.push_back({2'b00, len[7:0]});
    for (int i = 0; i < nbytes; i++) begin
      b = 8'(i + 1);
      cs = cs + b;
      exp_q.push_back({2'b00, b});
    end
`ifdef PACK_SEQ_TAIL_EN
    exp_q.push_back({2'b00, cs});
    exp_q.push_back({2'b00, 8'h0D});
    exp_q.push_back({2'b01, 8'h0A});
`else
    exp_q.push_back({2'b01, cs});
`endif
    @(posedge clk_sys); #1;
    len_cfg = len;
    trig_pack = 1'b1;
    fire_k = -1; sop_k = -1; busy1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_sys);
      if (k == 1) busy1 = busy;
      if (pk_sop && sop_k < 0) sop_k = k;
      if (fire_load) begin
        fire_k = k;
        break;
      end
      @(posedge clk_sys); #1;
      trig_pack = 1'b0;
    end
    trig_pack = 1'b0;
    chk("fire_seen", fire_k >= 0, 1);
    if (fire_k < 0) begin
      exp_q.delete();
      return;
    end
    if (chk_t) begin
      chk("t_busy", busy1, 1);
      chk("t_sop_cycle", sop_k, 2);
      chk("t_fire_cycle", fire_k, 6);
    end
    ovr_seen = 0;
    cnt_seen = 0;
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk_sys); #1;
      load_vld  = 1'b1;
      load_data = 8'(i + 1);
      done_load = (i == nbytes - 1);
      trig_pack = (i == ovr_at);
      @(negedge clk_sys);
      if (i == 0) chk("fire_one_cycle", fire_load, 0);
      if (err_ovr) ovr_seen++;
    end
    @(posedge clk_sys); #1;
    load_vld = 1'b0; done_load = 1'b0; trig_pack = 1'b0; load_data = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_sys);
      if (err_ovr) ovr_seen++;
      if (err_cnt) cnt_seen++;
      if (!busy) break;
    end
    chk("back_idle", busy, 0);
    m_fc = m_fc + 8'd1;
    chk("frame_cnt", frame_cnt, m_fc);
    chk("err_ovr", ovr_seen, (ovr_at >= 0) ? 1 : 0);
    chk("err_cnt", cnt_seen, exp_cnt);
    chk("len_load", len_load, len);
    chk("q_empty", exp_q.size(), 0);
  endtask

  task automatic reject(input logic [11:0] len);
    logic [11:0] prev;
    int el, bz;
    prev = len_load;
    el = 0; bz = 0;
    @(posedge clk_sys); #1;
    len_cfg = len;
    trig_pack = 1'b1;
    @(posedge clk_sys); #1;
    trig_pack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      if (err_len) el++;
      if (busy) bz++;
    end
    chk("rej_err_len", el, 1);
    chk("rej_busy", bz, 0);
    chk("rej_len_load", len_load, prev);
  endtask

  initial begin
    vecs[0] = '{12'd2,    18,    -1, 1'b0};  // basic frame, checksum 0xAD
    vecs[1] = '{12'd1,    9,     -1, 1'b0};
    vecs[2] = '{12'd3,    27,     1, 1'b0};  // trigger during LOAD
    vecs[3] = '{12'd2,    17,    -1, 1'b1};  // loader drops a byte
    vecs[4] = '{12'd5,    46,    -1, 1'b1};  // loader sends one extra
    vecs[5] = '{12'd4000, 36000, -1, 1'b0};  // largest length

    #12;
    chk("rst_pk", {pk_data, pk_vld, pk_sop, pk_eop}, 0);
    chk("rst_ctl", {busy, fire_load, err_ovr, err_len, err_cnt}, 0);
    chk("rst_cnt", {frame_cnt, len_load}, 0);
    @(negedge clk_sys);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++)
      run_frame(vecs[v].len, vecs[v].nbytes, vecs[v].ovr_at, vecs[v].exp_cnt, v == 0);

    reject(12'd0);
    reject(12'd4001);
    reject(12'd4095);

    // frame counter wrap through 0xFF -> 0x00
    for (int f = 0; f < 256; f++) run_frame(12'd1, 9, -1, 1'b0, 1'b0);

    // reset in the middle of LOAD aborts the frame without an eop
    mon_en = 1'b0;
    @(posedge clk_sys); #1;
    len_cfg = 12'd2;
    trig_pack = 1'b1;
    @(posedge clk_sys); #1;
    trig_pack = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_sys);
      if (fire_load) break;
    end
    chk("rst_seq_fire", fire_load, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys); #1;
      load_vld = 1'b1;
      load_data = 8'(i + 1);
    end
    rst_n = 1'b0;
    load_vld = 1'b0;
    #1;
    chk("mid_rst_pk", {pk_data, pk_vld, pk_sop, pk_eop}, 0);
    chk("mid_rst_ctl", {busy, fire_load, err_ovr, err_len, err_cnt}, 0);
    chk("mid_rst_cnt", {frame_cnt, len_load}, 0);
    exp_q.delete();
    m_fc = '0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_frame(12'd2, 18, -1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
